// File: rtl/multi_cycle_cu.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch, decode, execute, memory and
// write-back over a shared memory and ALU, with a wait-state handshake, a trap and a retire counter.
module multi_cycle_cu #(
   parameter bit          MEM_WAIT_EN = 1'b1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opc,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             IorD,
   output logic             IR_write,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             MemToReg,
   output logic             selR31,
   output logic             Jal,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALU_control,
   output logic [1:0]       PCSrc,
   output logic             pc_en,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StExR     = 4'd2,
      StWbR     = 4'd3,
      StExI     = 4'd4,
      StWbI     = 4'd5,
      StMemAddr = 4'd6,
      StMemRd   = 4'd7,
      StMemWb   = 4'd8,
      StMemWr   = 4'd9,
      StBranch  = 4'd10,
      StJump    = 4'd11,
      StJal     = 4'd12,
      StJr      = 4'd13,
      StTrap    = 4'd14
   } state_e;

   localparam logic [5:0] OpcR    = 6'b000000;
   localparam logic [5:0] OpcAddi = 6'b001000;
   localparam logic [5:0] OpcSlti = 6'b001010;
   localparam logic [5:0] OpcLw   = 6'b100011;
   localparam logic [5:0] OpcSw   = 6'b101011;
   localparam logic [5:0] OpcJ    = 6'b000010;
   localparam logic [5:0] OpcJal  = 6'b000011;
   localparam logic [5:0] OpcJr   = 6'b000111;
   localparam logic [5:0] OpcBeq  = 6'b000100;

   localparam logic [2:0] AluAnd = 3'b000;
   localparam logic [2:0] AluOr  = 3'b001;
   localparam logic [2:0] AluAdd = 3'b010;
   localparam logic [2:0] AluSub = 3'b110;
   localparam logic [2:0] AluSlt = 3'b111;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q;
   logic             rdy;
   logic             r_legal;
   logic [2:0]       r_alu;
   logic             pc_write, pc_write_cond;

   // Without wait states every memory access is assumed to complete in its first cycle.
   assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_comb begin
      r_legal = 1'b1;
      r_alu   = AluAnd;
      case (func)
         6'b100000: r_alu = AluAdd;
         6'b100010: r_alu = AluSub;
         6'b100100: r_alu = AluAnd;
         6'b100101: r_alu = AluOr;
         6'b101010: r_alu = AluSlt;
         default:   r_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      IorD          = 1'b0;
      IR_write      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      MemToReg      = 1'b0;
      selR31        = 1'b0;
      Jal           = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALU_control   = AluAnd;
      PCSrc         = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      illegal       = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_read    = 1'b1;
            ALUSrcB     = 2'b01;
            ALU_control = AluAdd;
            IR_write    = rdy;
            pc_write    = rdy;
            if (rdy) state_d = StDecode;
         end
         StDecode: begin
            // Branch target is computed here so BRANCH can compare while ALUOut holds it.
            ALUSrcB     = 2'b11;
            ALU_control = AluAdd;
            case (opc)
               OpcR:             state_d = r_legal ? StExR : StTrap;
               OpcAddi, OpcSlti: state_d = StExI;
               OpcLw, OpcSw:     state_d = StMemAddr;
               OpcBeq:           state_d = StBranch;
               OpcJ:             state_d = StJump;
               OpcJal:           state_d = StJal;
               OpcJr:            state_d = StJr;
               default:          state_d = StTrap;
            endcase
         end
         StExR: begin
            ALUSrcA     = 1'b1;
            ALU_control = r_alu;
            state_d     = StWbR;
         end
         StWbR: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StExI: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALU_control = (opc == OpcSlti) ? AluSlt : AluAdd;
            state_d     = StWbI;
         end
         StWbI: begin
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StMemAddr: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALU_control = AluAdd;
            state_d     = (opc == OpcLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_read = 1'b1;
            IorD     = 1'b1;
            if (rdy) state_d = StMemWb;
         end
         StMemWb: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StMemWr: begin
            mem_write = 1'b1;
            IorD      = 1'b1;
            if (rdy) state_d = StFetch;
         end
         StBranch: begin
            ALUSrcA       = 1'b1;
            ALU_control   = AluSub;
            pc_write_cond = 1'b1;
            PCSrc         = 2'b01;
            state_d       = StFetch;
         end
         StJump: begin
            pc_write = 1'b1;
            PCSrc    = 2'b10;
            state_d  = StFetch;
         end
         StJal: begin
            // PC already points past this instruction, so writing PC yields the return address.
            pc_write = 1'b1;
            PCSrc    = 2'b10;
            RegWrite = 1'b1;
            selR31   = 1'b1;
            Jal      = 1'b1;
            state_d  = StFetch;
         end
         StJr: begin
            pc_write = 1'b1;
            PCSrc    = 2'b11;
            state_d  = StFetch;
         end
         StTrap: begin
            illegal = 1'b1;
         end
         default: state_d = StTrap;
      endcase
   end

   assign pc_en = pc_write | (pc_write_cond & zero);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q != StFetch && state_d == StFetch) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed bench for multi_cycle_cu: per-cycle vector table plus reset, trap and no-wait sequences.
module tb_multi_cycle_cu;

   localparam logic [5:0] OR_   = 6'b000000;
   localparam logic [5:0] OAddi = 6'b001000;
   localparam logic [5:0] OSlti = 6'b001010;
   localparam logic [5:0] OLw   = 6'b100011;
   localparam logic [5:0] OSw   = 6'b101011;
   localparam logic [5:0] OJ    = 6'b000010;
   localparam logic [5:0] OJal  = 6'b000011;
   localparam logic [5:0] OJr   = 6'b000111;
   localparam logic [5:0] OBeq  = 6'b000100;
   localparam logic [5:0] FAdd  = 6'b100000;
   localparam logic [5:0] FSub  = 6'b100010;

   // mr mw iord irw rdst rw m2r s31 jal asa | asb | alu | pcs | pc_en | illegal
   localparam logic [18:0] KFetch  = 19'b1_0_0_1_0_0_0_0_0_0_01_010_00_1_0;
   localparam logic [18:0] KFetchW = 19'b1_0_0_0_0_0_0_0_0_0_01_010_00_0_0;
   localparam logic [18:0] KDec    = 19'b0_0_0_0_0_0_0_0_0_0_11_010_00_0_0;
   localparam logic [18:0] KExRAdd = 19'b0_0_0_0_0_0_0_0_0_1_00_010_00_0_0;
   localparam logic [18:0] KExRSub = 19'b0_0_0_0_0_0_0_0_0_1_00_110_00_0_0;
   localparam logic [18:0] KWbR    = 19'b0_0_0_0_1_1_0_0_0_0_00_000_00_0_0;
   localparam logic [18:0] KExIAdd = 19'b0_0_0_0_0_0_0_0_0_1_10_010_00_0_0;
   localparam logic [18:0] KExISlt = 19'b0_0_0_0_0_0_0_0_0_1_10_111_00_0_0;
   localparam logic [18:0] KWbI    = 19'b0_0_0_0_0_1_0_0_0_0_00_000_00_0_0;
   localparam logic [18:0] KMAddr  = 19'b0_0_0_0_0_0_0_0_0_1_10_010_00_0_0;
   localparam logic [18:0] KMRd    = 19'b1_0_1_0_0_0_0_0_0_0_00_000_00_0_0;
   localparam logic [18:0] KMWb    = 19'b0_0_0_0_0_1_1_0_0_0_00_000_00_0_0;
   localparam logic [18:0] KMWr    = 19'b0_1_1_0_0_0_0_0_0_0_00_000_00_0_0;
   localparam logic [18:0] KBrT    = 19'b0_0_0_0_0_0_0_0_0_1_00_110_01_1_0;
   localparam logic [18:0] KBrF    = 19'b0_0_0_0_0_0_0_0_0_1_00_110_01_0_0;
   localparam logic [18:0] KJump   = 19'b0_0_0_0_0_0_0_0_0_0_00_000_10_1_0;
   localparam logic [18:0] KJal    = 19'b0_0_0_0_0_1_0_1_1_0_00_000_10_1_0;
   localparam logic [18:0] KJr     = 19'b0_0_0_0_0_0_0_0_0_0_00_000_11_1_0;
   localparam logic [18:0] KTrap   = 19'b0_0_0_0_0_0_0_0_0_0_00_000_00_0_1;

   typedef struct {
      logic [5:0]  opc;
      logic [5:0]  func;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [18:0] ctrl;
      logic [31:0] ret;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opc = '0;
   logic [5:0]  func = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;

   logic        mem_read, mem_write, IorD, IR_write, RegDst, RegWrite, MemToReg, selR31, Jal;
   logic        ALUSrcA, pc_en, illegal;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [2:0]  ALU_control;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        nw_mem_read, nw_mem_write, nw_IorD, nw_IR_write, nw_RegDst, nw_RegWrite;
   logic        nw_MemToReg, nw_selR31, nw_Jal, nw_ALUSrcA, nw_pc_en, nw_illegal;
   logic [1:0]  nw_ALUSrcB, nw_PCSrc;
   logic [2:0]  nw_ALU_control;
   logic [3:0]  nw_state;
   logic [7:0]  nw_retired;

   logic [18:0] act;
   assign act = {mem_read, mem_write, IorD, IR_write, RegDst, RegWrite, MemToReg, selR31, Jal,
                 ALUSrcA, ALUSrcB, ALU_control, PCSrc, pc_en, illegal};

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   multi_cycle_cu #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .IorD(IorD), .IR_write(IR_write),
      .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg), .selR31(selR31), .Jal(Jal),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_control(ALU_control), .PCSrc(PCSrc),
      .pc_en(pc_en), .illegal(illegal), .state(state), .retired(retired)
   );

   multi_cycle_cu #(.MEM_WAIT_EN(1'b0), .CNT_W(8)) dut_nw (
      .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
      .mem_read(nw_mem_read), .mem_write(nw_mem_write), .IorD(nw_IorD),
      .IR_write(nw_IR_write), .RegDst(nw_RegDst), .RegWrite(nw_RegWrite),
      .MemToReg(nw_MemToReg), .selR31(nw_selR31), .Jal(nw_Jal), .ALUSrcA(nw_ALUSrcA),
      .ALUSrcB(nw_ALUSrcB), .ALU_control(nw_ALU_control), .PCSrc(nw_PCSrc),
      .pc_en(nw_pc_en), .illegal(nw_illegal), .state(nw_state), .retired(nw_retired)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, got, want);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input logic r, input logic [3:0] s, input logic [18:0] c,
                               input logic [31:0] n);
      vec_t v;
      v.opc = o; v.func = f; v.zero = z; v.rdy = r; v.st = s; v.ctrl = c; v.ret = n;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      opc = v.opc; func = v.func; zero = v.zero; mem_ready = v.rdy;
      #1;
      chk("state", idx, 32'(state), 32'(v.st));
      chk("ctrl", idx, 32'(act), 32'(v.ctrl));
      chk("retired", idx, retired, v.ret);
   endtask

   // Reset is released with mem_ready low so the waiting DUT stays in FETCH afterwards.
   task automatic do_reset(input int idx);
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_state", idx, 32'(state), 32'd0);
      chk("rst_retired", idx, retired, 32'd0);
      chk("rst_mem_read", idx, 32'(mem_read), 32'd1);
      chk("rst_iord", idx, 32'(IorD), 32'd0);
   endtask

   initial begin
      // lw with one fetch wait and three MEM_RD waits
      tbl.push_back(mk(OLw, 0, 0, 0, 0, KFetchW, 0));
      tbl.push_back(mk(OLw, 0, 0, 1, 0, KFetch, 0));
      tbl.push_back(mk(OLw, 0, 0, 0, 1, KDec, 0));
      tbl.push_back(mk(OLw, 0, 0, 0, 6, KMAddr, 0));
      tbl.push_back(mk(OLw, 0, 0, 0, 7, KMRd, 0));
      tbl.push_back(mk(OLw, 0, 0, 0, 7, KMRd, 0));
      tbl.push_back(mk(OLw, 0, 0, 0, 7, KMRd, 0));
      tbl.push_back(mk(OLw, 0, 0, 1, 7, KMRd, 0));
      tbl.push_back(mk(OLw, 0, 0, 0, 8, KMWb, 0));
      // sw with one wait; strobe held
      tbl.push_back(mk(OSw, 0, 0, 1, 0, KFetch, 1));
      tbl.push_back(mk(OSw, 0, 0, 0, 1, KDec, 1));
      tbl.push_back(mk(OSw, 0, 0, 1, 6, KMAddr, 1));
      tbl.push_back(mk(OSw, 0, 0, 0, 9, KMWr, 1));
      tbl.push_back(mk(OSw, 0, 0, 1, 9, KMWr, 1));
      // add, sub
      tbl.push_back(mk(OR_, FAdd, 0, 1, 0, KFetch, 2));
      tbl.push_back(mk(OR_, FAdd, 0, 0, 1, KDec, 2));
      tbl.push_back(mk(OR_, FAdd, 0, 0, 2, KExRAdd, 2));
      tbl.push_back(mk(OR_, FAdd, 0, 0, 3, KWbR, 2));
      tbl.push_back(mk(OR_, FSub, 0, 1, 0, KFetch, 3));
      tbl.push_back(mk(OR_, FSub, 0, 1, 1, KDec, 3));
      tbl.push_back(mk(OR_, FSub, 0, 1, 2, KExRSub, 3));
      tbl.push_back(mk(OR_, FSub, 0, 1, 3, KWbR, 3));
      // addi, slti
      tbl.push_back(mk(OAddi, 0, 0, 1, 0, KFetch, 4));
      tbl.push_back(mk(OAddi, 0, 0, 0, 1, KDec, 4));
      tbl.push_back(mk(OAddi, 0, 0, 0, 4, KExIAdd, 4));
      tbl.push_back(mk(OAddi, 0, 0, 0, 5, KWbI, 4));
      tbl.push_back(mk(OSlti, 0, 0, 1, 0, KFetch, 5));
      tbl.push_back(mk(OSlti, 0, 0, 0, 1, KDec, 5));
      tbl.push_back(mk(OSlti, 0, 0, 0, 4, KExISlt, 5));
      tbl.push_back(mk(OSlti, 0, 0, 0, 5, KWbI, 5));
      // beq taken / not taken
      tbl.push_back(mk(OBeq, 0, 1, 1, 0, KFetch, 6));
      tbl.push_back(mk(OBeq, 0, 1, 0, 1, KDec, 6));
      tbl.push_back(mk(OBeq, 0, 1, 0, 10, KBrT, 6));
      tbl.push_back(mk(OBeq, 0, 0, 1, 0, KFetch, 7));
      tbl.push_back(mk(OBeq, 0, 0, 0, 1, KDec, 7));
      tbl.push_back(mk(OBeq, 0, 0, 0, 10, KBrF, 7));
      // j, jal, jr
      tbl.push_back(mk(OJ, 0, 0, 1, 0, KFetch, 8));
      tbl.push_back(mk(OJ, 0, 0, 0, 1, KDec, 8));
      tbl.push_back(mk(OJ, 0, 0, 0, 11, KJump, 8));
      tbl.push_back(mk(OJal, 0, 0, 1, 0, KFetch, 9));
      tbl.push_back(mk(OJal, 0, 0, 0, 1, KDec, 9));
      tbl.push_back(mk(OJal, 0, 0, 0, 12, KJal, 9));
      tbl.push_back(mk(OJr, 0, 0, 1, 0, KFetch, 10));
      tbl.push_back(mk(OJr, 0, 0, 0, 1, KDec, 10));
      tbl.push_back(mk(OJr, 0, 0, 0, 13, KJr, 10));
      // lw parked in MEM_RD, then reset mid-wait
      tbl.push_back(mk(OLw, 0, 0, 1, 0, KFetch, 11));
      tbl.push_back(mk(OLw, 0, 0, 1, 1, KDec, 11));
      tbl.push_back(mk(OLw, 0, 0, 0, 6, KMAddr, 11));
      tbl.push_back(mk(OLw, 0, 0, 0, 7, KMRd, 11));
      tbl.push_back(mk(OLw, 0, 0, 0, 7, KMRd, 11));

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("init_state", 0, 32'(state), 32'd0);
      chk("init_retired", 0, retired, 32'd0);

      foreach (tbl[i]) apply(tbl[i], i);
      do_reset(1);

      // Unknown opcode traps and stays there
      apply(mk(6'b111111, 0, 0, 1, 0, KFetch, 0), 100);
      apply(mk(6'b111111, 0, 0, 1, 1, KDec, 0), 101);
      for (int i = 0; i < 10; i++) apply(mk(6'b111111, 0, 1, 1, 14, KTrap, 0), 102 + i);
      do_reset(2);

      // R-type with unknown func traps
      apply(mk(OR_, 6'b000001, 0, 1, 0, KFetch, 0), 120);
      apply(mk(OR_, 6'b000001, 0, 1, 1, KDec, 0), 121);
      apply(mk(OR_, 6'b000001, 0, 1, 14, KTrap, 0), 122);
      apply(mk(OR_, 6'b000001, 0, 1, 14, KTrap, 0), 123);
      do_reset(3);

      // No-wait instance: lw with mem_ready held low still takes 5 cycles
      opc = OLw;
      chk("nw_rst_state", 0, 32'(nw_state), 32'd0);
      chk("nw_fetch_irw", 0, 32'(nw_IR_write), 32'd1);
      begin
         logic [3:0] nw_exp [5];
         nw_exp = '{4'd1, 4'd6, 4'd7, 4'd8, 4'd0};
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("nw_state", i, 32'(nw_state), 32'(nw_exp[i]));
            if (nw_exp[i] == 4'd7) begin
               chk("nw_mem_read", i, 32'(nw_mem_read), 32'd1);
               chk("nw_iord", i, 32'(nw_IorD), 32'd1);
            end
         end
      end
      chk("nw_retired", 0, 32'(nw_retired), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_cycle_cu.md
Name: multi_cycle_cu

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 cycles through a shared memory and a single ALU.
- Decodes the same opcode set (R-type, addi, slti, lw, sw, j, jal, jr, beq) with ALU control folded in.
- Adds a memory wait-state handshake, an illegal-instruction trap, and a retired-instruction counter.
- Sits between the instruction register (opc/func fields) and the multi-cycle datapath muxes and enables.

Parameters:
- MEM_WAIT_EN, 1, 1: memory states hold until mem_ready=1; 0: memory states last exactly one cycle and mem_ready is ignored.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- opc  input  6  instruction[31:26] from IR.
- func  input  6  instruction[5:0] from IR.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete this cycle.
- mem_read, mem_write  output  1 each  memory strobes.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- IR_write  output  1  IR load enable.
- RegDst, RegWrite, MemToReg, selR31, Jal  output  1 each  register-file controls; Jal=1 selects PC as write data.
- ALUSrcA  output  1  ALU A input: 0=PC, 1=regA.
- ALUSrcB  output  2  ALU B input: 00=regB, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2.
- ALU_control  output  3  ALU op: and=000, or=001, add=010, sub=110, slt=111.
- PCSrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target, 11=regA.
- pc_en  output  1  pc_write | (pc_write_cond & zero).
- illegal  output  1  high while in TRAP.
- state  output  4  current state code, for debug.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Opcodes: R=000000, addi=001000, slti=001010, lw=100011, sw=101011, j=000010, jal=000011, jr=000111, beq=000100.
- R-type funcs: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- States: FETCH=0, DECODE=1, EX_R=2, WB_R=3, EX_I=4, WB_I=5, MEM_ADDR=6, MEM_RD=7, MEM_WB=8, MEM_WR=9, BRANCH=10, JUMP=11, JAL=12, JR=13, TRAP=14.
- Outputs are Moore; pc_en is a combinational function of state and zero. Any output not listed for a state is 0, including ALU_control=000.
- Reset: state=FETCH, retired=0. rst has priority over every transition, including mid-wait and TRAP.
- "rdy" below means mem_ready when MEM_WAIT_EN=1, and constant 1 when MEM_WAIT_EN=0.
- FETCH:
  - mem_read=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_control=add, PCSrc=00.
  - IR_write=rdy, pc_write=rdy.
  - Hold while !rdy; go to DECODE on rdy.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALU_control=add (precomputes branch target).
  - Next state: R with legal func→EX_R; addi/slti→EX_I; lw/sw→MEM_ADDR; beq→BRANCH; j→JUMP; jal→JAL; jr→JR.
  - Unknown opcode, or R-type with unknown func→TRAP.
- EX_R: ALUSrcA=1, ALUSrcB=00, ALU_control from func → WB_R.
- WB_R: RegDst=1, RegWrite=1 → FETCH.
- EX_I: ALUSrcA=1, ALUSrcB=10, ALU_control=add (addi) or slt (slti) → WB_I.
- WB_I: RegDst=0, RegWrite=1 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_control=add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, IorD=1; hold while !rdy → MEM_WB.
- MEM_WB: MemToReg=1, RegWrite=1 → FETCH.
- MEM_WR: mem_write=1, IorD=1; hold while !rdy → FETCH. Strobe stays high for every wait cycle.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_control=sub, pc_write_cond=1, PCSrc=01 → FETCH.
- JUMP: pc_write=1, PCSrc=10 → FETCH.
- JAL: pc_write=1, PCSrc=10, RegWrite=1, selR31=1, Jal=1 → FETCH. Writes PC+4 (the PC already advanced in FETCH).
- JR: pc_write=1, PCSrc=11 → FETCH.
- TRAP: illegal=1, all write enables and strobes 0; stays until rst.
- retired: increments by 1 (wraps modulo 2^CNT_W) on each transition into FETCH from a non-FETCH state.
- Cycle counts (no waits): R/addi/slti=4, lw=5, sw=4, beq/j/jal/jr=3. Each memory wait cycle adds one.

Test Plan:
- rst=1 for 2 cycles mid-MEM_RD → state=0, retired=0, mem_read=1/IorD=0 (FETCH) the cycle after release.
- add (opc=000000, func=100000), mem_ready=1 → states 0,1,2,3,0; ALU_control=010 in EX_R; RegWrite=1, RegDst=1 only in WB_R; retired=1.
- lw with mem_ready low 3 cycles in MEM_RD, MEM_WAIT_EN=1 → MEM_RD lasts 4 cycles with mem_read=1, IorD=1; then MEM_WB with MemToReg=1, RegWrite=1. Same stimulus with MEM_WAIT_EN=0 → MEM_RD lasts 1 cycle.
- beq with zero=1 → pc_en=1, PCSrc=01 in BRANCH; with zero=0 → pc_en=0; both return to FETCH after 3 cycles.
- jal → JAL: pc_en=1, PCSrc=10, RegWrite=1, selR31=1, Jal=1. jr (000111) → PCSrc=11, RegWrite=0.
- opc=111111, or opc=000000 with func=000001 → TRAP: illegal=1, state=14, held 10 cycles, retired unchanged; rst → FETCH.
